// File: rtl/doorlock_param.sv
// doorlock_param: parametrised keypad door-lock controller.
//
// A code is entered as: x press (start), N_DIGITS one-hot digit presses, x press
// (confirm). The entry is compared against a reprogrammable stored code. Success
// lights out_led_1, failure lights out_led_2, and MAX_FAIL consecutive failures
// start a lockout (out_lock + out_led_2). While the open LED is lit, a prog press
// starts programming a new code, which is confirmed the same way as an entry.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   num[9:0]   in   digit button levels, bit i = digit i
//   x          in   start/confirm button level
//   prog       in   program-new-code request level
//   out_led_1  out  open (success) LED
//   out_led_2  out  fail LED (also lit during lockout)
//   out_lock   out  lockout active
//   button_on  out  num registered one clock (panel echo)
module doorlock_param #(
  parameter int                            N_DIGITS       = 4,
  parameter int                            DIGIT_W        = 4,
  parameter logic [N_DIGITS*DIGIT_W-1:0]   DEFAULT_CODE   = 16'h5290,
  parameter int                            MAX_FAIL       = 3,
  parameter int                            LED_CYCLES     = 50,
  parameter int                            LOCK_CYCLES    = 1000,
  parameter int                            TIMEOUT_CYCLES = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] num,
  input  logic       x,
  input  logic       prog,
  output logic       out_led_1,
  output logic       out_led_2,
  output logic       out_lock,
  output logic [9:0] button_on
);

  localparam int CODE_W = N_DIGITS * DIGIT_W;
  localparam int T_MAX0 = (LED_CYCLES > LOCK_CYCLES) ? LED_CYCLES : LOCK_CYCLES;
  localparam int T_MAX  = (T_MAX0 > TIMEOUT_CYCLES) ? T_MAX0 : TIMEOUT_CYCLES;
  // The timer only ever reaches T_MAX-1 before it is cleared.
  localparam int TMR_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int CNT_W  = $clog2(N_DIGITS + 1);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ENTRY = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_OPEN  = 3'd3;
  localparam logic [2:0] S_PROG  = 3'd4;
  localparam logic [2:0] S_FAIL  = 3'd5;
  localparam logic [2:0] S_LOCK  = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [9:0]        num_q, num_d;
  logic              x_q, x_d;
  logic              prog_q, prog_d;
  logic              led1_q, led1_d;
  logic              led2_q, led2_d;
  logic              lock_q, lock_d;

  logic [9:0]         num_press;
  logic               x_press;
  logic               prog_press;
  logic [3:0]         n_press;
  logic [DIGIT_W-1:0] digit;
  logic               digit_vld;
  logic               full;
  logic [CODE_W-1:0]  cap_buf;
  logic [CNT_W-1:0]   cap_cnt;
  logic               cap_ovf;
  logic               match;
  logic [FAIL_W-1:0]  fail_inc;

  assign num_press  = num & ~num_q;
  assign x_press    = x & ~x_q;
  assign prog_press = prog & ~prog_q;

  // A digit counts only when exactly one button rose this cycle.
  always_comb begin
    n_press = 4'd0;
    digit   = '0;
    for (int i = 0; i < 10; i++) begin
      if (num_press[i]) begin
        digit   = DIGIT_W'(i);
        n_press = n_press + 4'd1;
      end
    end
    digit_vld = (n_press == 4'd1);
  end

  // Result of capturing this cycle's digit; used so that a digit arriving with
  // the confirming x press is part of the checked/programmed entry.
  always_comb begin
    full    = (count_q == CNT_W'(N_DIGITS));
    cap_buf = buf_q;
    cap_cnt = count_q;
    cap_ovf = ovf_q;
    if (digit_vld) begin
      cap_buf = (buf_q << DIGIT_W) | CODE_W'(digit);
      cap_cnt = full ? count_q : count_q + CNT_W'(1);
      cap_ovf = ovf_q | full;
    end
  end

  assign match    = (count_q == CNT_W'(N_DIGITS)) && !ovf_q && (buf_q == code_q);
  assign fail_inc = fail_cnt_q + FAIL_W'(1);

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    buf_d      = buf_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    fail_cnt_d = fail_cnt_q;
    timer_d    = '0;
    num_d      = num;
    x_d        = x;
    prog_d     = prog;
    case (state_q)
      S_IDLE: begin
        if (x_press) begin
          state_d = S_ENTRY;
          buf_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      S_ENTRY, S_PROG: begin
        buf_d   = cap_buf;
        count_d = cap_cnt;
        ovf_d   = cap_ovf;
        if (x_press) begin
          if (state_q == S_ENTRY) begin
            state_d = S_CHECK;
          end else if ((cap_cnt == CNT_W'(N_DIGITS)) && !cap_ovf) begin
            code_d  = cap_buf;
            state_d = S_IDLE;
          end else begin
            state_d = S_FAIL;
          end
        end else if (digit_vld) begin
          timer_d = '0;
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          // Abandoned entry: back to idle without touching fail_cnt.
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_CHECK: begin
        if (match) begin
          state_d    = S_OPEN;
          fail_cnt_d = '0;
        end else begin
          fail_cnt_d = fail_inc;
          state_d    = (fail_inc == FAIL_W'(MAX_FAIL)) ? S_LOCK : S_FAIL;
        end
      end
      S_OPEN: begin
        if (prog_press) begin
          state_d = S_PROG;
          buf_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (timer_q == TMR_W'(LED_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_FAIL: begin
        if (timer_q == TMR_W'(LED_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_LOCK: begin
        if (timer_q == TMR_W'(LOCK_CYCLES - 1)) begin
          state_d    = S_IDLE;
          fail_cnt_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are decoded from the next state so they switch with the state.
    led1_d = (state_d == S_OPEN);
    led2_d = (state_d == S_FAIL) || (state_d == S_LOCK);
    lock_d = (state_d == S_LOCK);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      code_q     <= DEFAULT_CODE;
      buf_q      <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      fail_cnt_q <= '0;
      timer_q    <= '0;
      num_q      <= '0;
      x_q        <= 1'b0;
      prog_q     <= 1'b0;
      led1_q     <= 1'b0;
      led2_q     <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      buf_q      <= buf_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      fail_cnt_q <= fail_cnt_d;
      timer_q    <= timer_d;
      num_q      <= num_d;
      x_q        <= x_d;
      prog_q     <= prog_d;
      led1_q     <= led1_d;
      led2_q     <= led2_d;
      lock_q     <= lock_d;
    end
  end

  // Edge-detect history doubles as the registered panel echo.
  assign button_on = num_q;
  assign out_led_1 = led1_q;
  assign out_led_2 = led2_q;
  assign out_lock  = lock_q;

endmodule
